// File: rtl/button_pkg.sv
// Shared defaults and the per-channel output bundle for the button conditioner.
package button_pkg;

  localparam int DEF_CHANNELS        = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 1000;
  localparam int DEF_REPEAT_PERIOD   = 250;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic press;
  } btn_out_t;

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debouncer, registered edge pulses and,
// when BUTTON_REPEAT_EN is defined, hold-to-repeat press pulses.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
    $error("button_channel: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  btn_out_t               out_q, out_d;
  logic                   sync, accept, level_nxt, rise_ev, fall_ev, rep_fire;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], button};
    accept    = (sync != out_q.level) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    level_nxt = accept ? sync : out_q.level;
    rise_ev   = accept & sync;
    fall_ev   = accept & ~sync;
    // Any sample agreeing with the current level restarts qualification.
    if (sync == out_q.level || accept) cnt_d = '0;
    else                               cnt_d = cnt_q + 1'b1;
  end

`ifdef BUTTON_REPEAT_EN
  localparam int HC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HC_W   = $clog2(HC_MAX + 1);

  logic [HC_W-1:0] hc_q, hc_d, hc_inc, hc_tgt;
  logic            rep_q, rep_d;

  // rep_q flags that the initial delay has elapsed; hc restarts at each fire
  // so the period stays exact and the counter never exceeds HC_MAX.
  always_comb begin
    hc_inc   = hc_q + 1'b1;
    hc_tgt   = rep_q ? HC_W'(REPEAT_PERIOD) : HC_W'(REPEAT_DELAY);
    hc_d     = hc_inc;
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (rise_ev || !level_nxt) begin
      hc_d  = '0;
      rep_d = 1'b0;
    end else if (hc_inc == hc_tgt) begin
      rep_fire = 1'b1;
      hc_d     = '0;
      rep_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q  <= '0;
      rep_q <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      rep_q <= rep_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    out_d.level = level_nxt;
    out_d.rise  = rise_ev;
    out_d.fall  = fall_ev;
    out_d.press = rise_ev | rep_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign level = out_q.level;
  assign rise  = out_q.rise;
  assign fall  = out_q.fall;
  assign press = out_q.press;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end; one independent button_channel per input.
// Hold-to-repeat is built only when BUTTON_REPEAT_EN is defined.
module button_conditioner
  import button_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .button(button[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .press (press[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: 4 channels, debounce 4, repeat 10/4.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] button = 4'h0;
  logic [3:0] level, rise, fall, press;
  logic [15:0] obs, exp_v;
  logic [3:0] lv, rs, fl, pr;
  int nvec = 0;
  int nerr = 0;

`ifdef BUTTON_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  button_conditioner #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .rst(rst), .button(button),
    .level(level), .rise(rise), .fall(fall), .press(press)
  );

  always #5 clk = ~clk;
  assign obs = {level, rise, fall, press};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    button = 4'h0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    button = 4'hF;
    repeat (3) tick();
    exp_v = 16'h0;
    nvec++;
    if (obs !== exp_v) begin nerr++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      lv = (e >= 6) ? 4'hF : 4'h0;
      rs = (e == 6) ? 4'hF : 4'h0;
      exp_v = {lv, rs, 4'h0, rs};
      nvec++;
      if (obs !== exp_v) begin nerr++; $display("FAIL reset_release e%0d: got %h want %h", e, obs, exp_v); end
    end
  endtask

  task automatic test_clean();
    do_reset();
    button = 4'h1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      lv = (e >= 6) ? 4'h1 : 4'h0;
      rs = (e == 6) ? 4'h1 : 4'h0;
      exp_v = {lv, rs, 4'h0, rs};
      nvec++;
      if (obs !== exp_v) begin nerr++; $display("FAIL clean_press e%0d: got %h want %h", e, obs, exp_v); end
    end
    button = 4'h0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      lv = (e < 6) ? 4'h1 : 4'h0;
      fl = (e == 6) ? 4'h1 : 4'h0;
      exp_v = {lv, 4'h0, fl, 4'h0};
      nvec++;
      if (obs !== exp_v) begin nerr++; $display("FAIL clean_release e%0d: got %h want %h", e, obs, exp_v); end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat [4];
    pat[0] = 4'h2; pat[1] = 4'h0; pat[2] = 4'h2; pat[3] = 4'h0;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      button = pat[b];
      tick();
      exp_v = 16'h0;
      nvec++;
      if (obs !== exp_v) begin nerr++; $display("FAIL bounce_toggle b%0d: got %h want %h", b, obs, exp_v); end
    end
    button = 4'h2;
    for (int e = 1; e <= 9; e++) begin
      tick();
      lv = (e >= 6) ? 4'h2 : 4'h0;
      rs = (e == 6) ? 4'h2 : 4'h0;
      exp_v = {lv, rs, 4'h0, rs};
      nvec++;
      if (obs !== exp_v) begin nerr++; $display("FAIL bounce_hold e%0d: got %h want %h", e, obs, exp_v); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    button = 4'h4;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 3) button = 4'h0;
      exp_v = 16'h0;
      nvec++;
      if (obs !== exp_v) begin nerr++; $display("FAIL glitch e%0d: got %h want %h", e, obs, exp_v); end
    end
  endtask

  task automatic test_repeat();
    int k;
    do_reset();
    button = 4'h8;
    for (int e = 1; e <= 45; e++) begin
      tick();
      if (e == 29) button = 4'h0;
      k = e - 6;
      lv = (k >= 0 && k < 29) ? 4'h8 : 4'h0;
      rs = (k == 0) ? 4'h8 : 4'h0;
      fl = (k == 29) ? 4'h8 : 4'h0;
      pr = rs;
      if (REP_EN && k >= 10 && k < 29 && ((k - 10) % 4) == 0) pr = 4'h8;
      exp_v = {lv, rs, fl, pr};
      nvec++;
      if (obs !== exp_v) begin nerr++; $display("FAIL repeat k%0d: got %h want %h", k, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    button = 4'h1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    exp_v = 16'h0;
    nvec++;
    if (obs !== exp_v) begin nerr++; $display("FAIL mid_debounce_rst: got %h want %h", obs, exp_v); end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      lv = (e >= 6) ? 4'h1 : 4'h0;
      rs = (e == 6) ? 4'h1 : 4'h0;
      exp_v = {lv, rs, 4'h0, rs};
      nvec++;
      if (obs !== exp_v) begin nerr++; $display("FAIL requalify e%0d: got %h want %h", e, obs, exp_v); end
    end
    repeat (11) tick();
    rst = 1'b1;
    button = 4'h0;
    tick();
    exp_v = 16'h0;
    nvec++;
    if (obs !== exp_v) begin nerr++; $display("FAIL mid_repeat_rst: got %h want %h", obs, exp_v); end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      nvec++;
      if (obs !== exp_v) begin nerr++; $display("FAIL post_rst_quiet e%0d: got %h want %h", e, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_glitch();
    test_repeat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
